shift_iter: RTL and testbench
=============================

SHIFT_ITER -- requirements
Module: shift_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the data width; a power of two, >= 8.
REQ-002 The block SHALL have parameter STEP, default 8, the maximum bits shifted per cycle; a power of two, 1..WIDTH.
REQ-003 The block SHALL derive localparam SHW = clog2(WIDTH), the shift-amount width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1, request present.
REQ-007 The block SHALL have port in_ready, output, 1, block can accept a request.
REQ-008 The block SHALL have port a, input, WIDTH, operand.
REQ-009 The block SHALL have port shamt, input, SHW, shift amount.
REQ-010 The block SHALL have port mode, input, 2, operation: 00 SRL, 01 SLL, 10 SRA, 11 ROR.
REQ-011 The block SHALL have port enable, input, 1, shift enable; 0 = pass operand through.
REQ-012 The block SHALL have port out_valid, output, 1, result present.
REQ-013 The block SHALL have port out_ready, input, 1, consumer takes the result.
REQ-014 The block SHALL have port b, output, WIDTH, result.
REQ-015 The block SHALL have port busy, output, 1, high in SHIFT or DONE.

Function
REQ-016 The block SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-017 The block SHALL assert in_ready only in IDLE with rst_n high; in_valid in any other state SHALL be ignored.
REQ-018 On accept (in_valid & in_ready), the block SHALL latch a, shamt, mode and enable; inputs SHALL be don't-care afterwards.
REQ-019 On an accept with enable=0 or shamt=0, the block SHALL enter DONE next cycle with b = a.
REQ-020 Otherwise it SHALL enter SHIFT; each SHIFT cycle shifts the working value by k = min(remaining, STEP) and decrements remaining by k.
REQ-021 The block SHALL go to DONE when remaining reaches 0; accept-to-out_valid latency SHALL be max(1, ceil(shamt/STEP)) cycles.
REQ-022 SRL and SLL SHALL zero-fill; SRA SHALL fill with bit WIDTH-1 of the latched operand; ROR SHALL rotate right.
REQ-023 In DONE, out_valid SHALL be 1 and b SHALL hold stable until out_valid & out_ready, then the state SHALL return to IDLE.
REQ-024 The block SHALL NOT overlap requests; the earliest next accept SHALL be the cycle after the result handshake.
REQ-025 b SHALL keep the last result in IDLE; out_valid SHALL be 0 outside DONE.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, out_valid 0, b 0, busy 0, in_ready 0, and remaining 0.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no result delivered.
REQ-028 The first accept SHALL be possible on the first rising edge after rst_n rises.

Configuration
REQ-029 Macro SHIFT_ROTATE_EN, when defined, SHALL enable mode 11 as ROR with the latency of REQ-021.
REQ-030 When SHIFT_ROTATE_EN is undefined, mode 11 SHALL produce b = 0 in DONE one cycle after accept regardless of shamt, and the rotate logic SHALL be absent.

Verification (WIDTH=32, STEP=8)
REQ-031 SRL: a=0xF0000000, shamt=12, mode 00 -> b=0x000F0000, out_valid 2 cycles after accept.
REQ-032 SRA: a=0x80000000, shamt=31, mode 10 -> b=0xFFFFFFFF after 4 cycles; SLL a=0x00000001 shamt=0 -> b=0x00000001 after 1 cycle; enable=0, shamt=20 -> b=a after 1 cycle.
REQ-033 ROR: a=0x12345678, shamt=8, mode 11 -> 0x78123456 after 1 cycle with SHIFT_ROTATE_EN; b=0x00000000 after 1 cycle without it.
REQ-034 Backpressure: out_ready=0 for 5 cycles in DONE -> b and out_valid held, in_ready 0, in_valid pulses ignored; the result is accepted when out_ready=1.
REQ-035 Reset mid-op: rst_n low in the 2nd cycle of a 4-cycle SRA -> out_valid 0, b 0 at once; a subsequent SLL a=0x1, shamt=9 -> b=0x00000200 after 2 cycles.

Source files
------------

// File: rtl/shift_iter.sv
// shift_iter: iterative shifter that moves the operand at most STEP bit
// positions per clock, with a valid/ready request and result handshake.
// Modes: 00 SRL, 01 SLL, 10 SRA, 11 ROR.
// Optional feature: define SHIFT_ROTATE_EN to enable mode 11 as rotate-right.
// Without it, mode 11 (with enable set) returns zero one cycle after accept.
module shift_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 8,
  localparam int unsigned SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       mode,
  input  logic             enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b,
  output logic             busy
);

  localparam logic [1:0] MODE_SRL = 2'b00;
  localparam logic [1:0] MODE_SLL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   remaining;
  logic [1:0]       mode_q;

  logic [SHW-1:0]   k_in;
  logic [SHW-1:0]   k_w;
  logic [WIDTH-1:0] first_val;
  logic [WIDTH-1:0] next_val;

  // Bits to move this cycle: min(rem, STEP); rem < WIDTH so the result fits SHW bits.
  function automatic logic [SHW-1:0] step_of(input logic [SHW-1:0] rem);
    return (32'(rem) > STEP) ? SHW'(STEP) : rem;
  endfunction

  // One partial shift of v by k. SRA keeps filling with v's top bit, which
  // stays equal to the latched operand's sign bit across all partial steps.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] v,
                                                input logic [1:0]       m,
                                                input logic [SHW-1:0]   k);
    logic [WIDTH-1:0] r;
    r = '0;
    case (m)
      MODE_SRL: r = v >> k;
      MODE_SLL: r = v << k;
      MODE_SRA: r = WIDTH'($signed(v) >>> k);
      MODE_ROR: begin
`ifdef SHIFT_ROTATE_EN
        r = WIDTH'({v, v} >> k);
`else
        r = '0;
`endif
      end
      default:  r = '0;
    endcase
    return r;
  endfunction

  // First step is taken on the accept edge, later steps from the working register.
  assign k_in      = step_of(shamt);
  assign first_val = shift_by(a, mode, k_in);
  assign k_w       = step_of(remaining);
  assign next_val  = shift_by(work, mode_q, k_w);

  // Handshake/status flags decoded straight from the state register.
  assign in_ready  = rst_n & (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Control FSM plus datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      remaining <= '0;
      mode_q    <= MODE_SRL;
      b         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mode_q <= mode;
            if (!enable) begin
              b         <= a;
              remaining <= '0;
              state     <= DONE;
            end
`ifndef SHIFT_ROTATE_EN
            else if (mode == MODE_ROR) begin
              b         <= '0;
              remaining <= '0;
              state     <= DONE;
            end
`endif
            else if (shamt == k_in) begin
              // Whole shift (including shamt = 0) fits in a single step.
              b         <= first_val;
              remaining <= '0;
              state     <= DONE;
            end else begin
              work      <= first_val;
              remaining <= shamt - k_in;
              state     <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work      <= next_val;
          remaining <= remaining - k_w;
          if (remaining == k_w) begin
            b     <= next_val;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_iter.sv
// tb_shift_iter: randomized and directed stimulus for shift_iter (WIDTH=32,
// STEP=8), checked every cycle against a behavioural model of the block.
module tb_shift_iter;

  localparam int unsigned W  = 32;
  localparam int unsigned SH = 5;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a         = '0;
  logic [SH-1:0] shamt     = '0;
  logic [1:0]    mode      = '0;
  logic          enable    = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  b;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  shift_iter #(.WIDTH(W), .STEP(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shamt     (shamt),
    .mode      (mode),
    .enable    (enable),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b         (b),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Reference result from plain arithmetic.
  function automatic logic [W-1:0] ref_res(input logic [W-1:0] x, input logic [SH-1:0] s,
                                           input logic [1:0] m, input logic en);
    if (!en) return x;
`ifndef SHIFT_ROTATE_EN
    if (m == 2'b11) return '0;
`endif
    if (s == 0) return x;
    case (m)
      2'b00:   return x >> s;
      2'b01:   return x << s;
      2'b10:   return W'($signed(x) >>> s);
      default: return (x >> s) | (x << (32 - int'(s)));
    endcase
  endfunction

  // Accept-to-result latency in cycles.
  function automatic int ref_lat(input logic [SH-1:0] s, input logic [1:0] m, input logic en);
    if (!en || s == 0) return 1;
`ifndef SHIFT_ROTATE_EN
    if (m == 2'b11) return 1;
`endif
    return (int'(s) + 7) / 8;
  endfunction

  // Behavioural model: pending/done flags, a cycle countdown and the result.
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  int           m_cnt  = 0;
  logic [W-1:0] m_b    = '0;
  logic [W-1:0] m_res  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
      m_b    = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_res  = ref_res(a, shamt, mode, enable);
        m_cnt  = ref_lat(shamt, mode, enable) - 1;
        m_busy = 1'b1;
        m_done = (m_cnt == 0);
        if (m_done) m_b = m_res;
      end
    end else if (m_done) begin
      if (out_ready) begin
        m_busy = 1'b0;
        m_done = 1'b0;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        m_b    = m_res;
      end
    end
  end

  // Per-cycle compare of DUT outputs against the model.
  always @(negedge clk) begin
    chk("in_ready",  W'(in_ready),  W'(rst_n && !m_busy));
    chk("out_valid", W'(out_valid), W'(m_done));
    chk("busy",      W'(busy),      W'(m_busy));
    if (!m_busy || m_done) chk("b", b, m_b);
  end

  // Issue one request from IDLE, measure latency, hold in DONE, then handshake.
  task automatic run_op(input logic [W-1:0] ta, input logic [SH-1:0] ts, input logic [1:0] tm,
                        input logic te, input int hold, output int lat, output logic [W-1:0] got);
    a = ta; shamt = ts; mode = tm; enable = te; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; shamt = SH'($urandom); mode = 2'($urandom); enable = 1'($urandom);
    lat = 0;
    got = '0;
    for (int i = 0; i < 40; i++) begin
      lat++;
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk); #1;
    end
    if (!out_valid) begin
      n_checks++;
      $display("FAIL timeout: out_valid never rose for a=%h shamt=%0d mode=%0d", ta, ts, tm);
    end
    got = b;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom);
      a = $urandom;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic directed(input string name, input logic [W-1:0] ta, input logic [SH-1:0] ts,
                          input logic [1:0] tm, input logic te, input logic [W-1:0] exp_b,
                          input int exp_lat, input int hold);
    int           lat;
    logic [W-1:0] got;
    run_op(ta, ts, tm, te, hold, lat, got);
    chk({name, " latency"}, W'(lat), W'(exp_lat));
    chk({name, " b"}, got, exp_b);
    chk({name, " model"}, m_b, exp_b);
  endtask

  initial begin
    int           lat;
    logic [W-1:0] got;
    logic [W-1:0] ra;
    logic [SH-1:0] rs;
    logic [1:0]   rm;
    logic         re;
    int           sel;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    directed("SRL 12",        32'hF000_0000, 5'd12, 2'b00, 1'b1, 32'h000F_0000, 2, 0);
    directed("SRA 31",        32'h8000_0000, 5'd31, 2'b10, 1'b1, 32'hFFFF_FFFF, 4, 1);
    directed("SLL 0",         32'h0000_0001, 5'd0,  2'b01, 1'b1, 32'h0000_0001, 1, 0);
    directed("enable 0",      32'hDEAD_BEEF, 5'd20, 2'b00, 1'b0, 32'hDEAD_BEEF, 1, 0);
`ifdef SHIFT_ROTATE_EN
    directed("ROR 8",         32'h1234_5678, 5'd8,  2'b11, 1'b1, 32'h7812_3456, 1, 0);
    directed("ROR 20",        32'h1234_5678, 5'd20, 2'b11, 1'b1, 32'h4567_8123, 3, 0);
`else
    directed("ROR off",       32'h1234_5678, 5'd8,  2'b11, 1'b1, 32'h0000_0000, 1, 0);
    directed("ROR off 20",    32'h1234_5678, 5'd20, 2'b11, 1'b1, 32'h0000_0000, 1, 0);
`endif
    directed("SRL step",      32'hFFFF_0000, 5'd8,  2'b00, 1'b1, 32'h00FF_FF00, 1, 0);
    directed("SRL 16",        32'hFFFF_0000, 5'd16, 2'b00, 1'b1, 32'h0000_FFFF, 2, 0);
    directed("SLL 31",        32'h0000_0003, 5'd31, 2'b01, 1'b1, 32'h8000_0000, 4, 0);
    directed("SRA pos 9",     32'h4000_0000, 5'd9,  2'b10, 1'b1, 32'h0020_0000, 2, 0);
    directed("backpressure",  32'hF000_0000, 5'd12, 2'b00, 1'b1, 32'h000F_0000, 2, 5);

    // Abort a 4-cycle SRA in its second cycle.
    a = 32'h8000_0000; shamt = 5'd31; mode = 2'b10; enable = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("reset out_valid", W'(out_valid), W'(0));
    chk("reset b",         b,             W'(0));
    chk("reset busy",      W'(busy),      W'(0));
    chk("reset in_ready",  W'(in_ready),  W'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    directed("post-reset SLL", 32'h0000_0001, 5'd9, 2'b01, 1'b1, 32'h0000_0200, 2, 0);

    // Randomized requests; the per-cycle compare carries most of the checking.
    for (int n = 0; n < 80; n++) begin
      ra  = $urandom;
      rm  = 2'($urandom);
      re  = ($urandom_range(0, 7) != 0);
`ifndef SHIFT_ROTATE_EN
      if (rm == 2'b11) re = 1'b1;
`endif
      sel = $urandom_range(0, 9);
      if (sel == 0)      rs = '0;
      else if (sel == 1) rs = 5'd31;
      else               rs = SH'($urandom);
      run_op(ra, rs, rm, re, $urandom_range(0, 3), lat, got);
      chk("random latency", W'(lat), W'(ref_lat(rs, rm, re)));
      chk("random b", got, ref_res(ra, rs, rm, re));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
